// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two requesters sharing one fixed-latency memory port.
// Optional MEM_ARB_LOCK_EN adds m1_lock so the loader can keep the bus during bursts.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy,
  output logic              o_dbg_state
);

  if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_bad_lat
    $fatal(1, "mem_arbiter: MEM_LAT must be in 1..8");
  end

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_WAIT = 1'b1;
  localparam logic [2:0] LAT_M1  = 3'(MEM_LAT - 1);

  logic       r_state;
  logic [2:0] r_cnt;
  logic       r_owner;
  logic       r_last;

  logic       w_lock;
  logic       w_win;
  logic       w_accept;
  logic       w_done;

`ifdef MEM_ARB_LOCK_EN
  assign w_lock = m1_lock;
`else
  assign w_lock = 1'b0;
`endif

  // Handshake: a requester holds req until it sees gnt in the same cycle;
  // gnt means accepted, and exactly one rvalid pulse follows MEM_LAT cycles later.
  always_comb begin
    w_win = 1'b0;
    if (m0_req && m1_req) begin
      w_win = (w_lock && r_last) ? 1'b1 : ~r_last;
    end else begin
      w_win = m1_req;
    end
  end

  // rst_n gates the combinational grant so every output is 0 while reset is held.
  assign w_accept = rst_n && (r_state == ST_IDLE) && (m0_req || m1_req);
  assign w_done   = (r_state == ST_WAIT) && (r_cnt == 3'd0);

  assign m0_gnt    = w_accept && !w_win;
  assign m1_gnt    = w_accept && w_win;
  assign mem_en    = w_accept;
  assign mem_we    = w_accept && (w_win ? m1_we : m0_we);
  assign mem_addr  = w_accept ? (w_win ? m1_addr : m0_addr) : '0;
  assign mem_wdata = w_accept ? (w_win ? m1_wdata : m0_wdata) : '0;

  assign m0_rvalid = w_done && !r_owner;
  assign m1_rvalid = w_done && r_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  assign arb_busy    = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_WAIT;
            r_owner <= w_win;
            r_cnt   <= LAT_M1;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid;
  logic [31:0] a_m0_rdata, a_m1_rdata;
  logic        a_mem_en, a_mem_we, a_busy, a_dbg, a_m1_lock;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_mem_en, b_mem_we, b_busy, b_dbg, b_m1_lock;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
`ifdef MEM_ARB_LOCK_EN
    .m1_lock(a_m1_lock),
`endif
    .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt), .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid),
    .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .arb_busy(a_busy), .o_dbg_state(a_dbg)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
`ifdef MEM_ARB_LOCK_EN
    .m1_lock(b_m1_lock),
`endif
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
    .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .arb_busy(b_busy), .o_dbg_state(b_dbg)
  );

  // Memory models: unwritten word i reads as 0xA5000000 + i; rdata is 0 outside the valid cycle.
  logic [31:0] mem_a [0:63];
  logic [63:0] vld_a;
  logic [5:0]  idx_a;
  assign idx_a = a_mem_addr[7:2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a       <= '0;
      a_mem_rdata <= '0;
    end else begin
      a_mem_rdata <= '0;
      if (a_mem_en && a_mem_we) begin
        mem_a[idx_a] <= a_mem_wdata;
        vld_a[idx_a] <= 1'b1;
      end else if (a_mem_en) begin
        a_mem_rdata <= vld_a[idx_a] ? mem_a[idx_a] : 32'hA500_0000 + 32'(idx_a);
      end
    end
  end

  logic [31:0] mem_b [0:63];
  logic [63:0] vld_b;
  logic [5:0]  idx_b;
  logic [31:0] p1_b, p2_b;
  assign idx_b = b_mem_addr[7:2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_b       <= '0;
      p1_b        <= '0;
      p2_b        <= '0;
      b_mem_rdata <= '0;
    end else begin
      p1_b        <= '0;
      p2_b        <= p1_b;
      b_mem_rdata <= p2_b;
      if (b_mem_en && b_mem_we) begin
        mem_b[idx_b] <= b_mem_wdata;
        vld_b[idx_b] <= 1'b1;
      end else if (b_mem_en) begin
        p1_b <= vld_b[idx_b] ? mem_b[idx_b] : 32'hA500_0000 + 32'(idx_b);
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = '0; a_m1_wdata = '0; a_m1_lock = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = '0; b_m1_wdata = '0; b_m1_lock = 0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    check("rst_a_ctl", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we, a_busy}, 32'h0);
    check("rst_b_ctl", {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_mem_we, b_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] t2_gnt [0:7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] t2_rv  [0:7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lone m0 read of 0x10 with MEM_LAT=1
    reset_all();
    @(negedge clk); a_m0_req = 1; a_m0_addr = 32'h10; #1;
    check("t1_gnt", {a_m1_gnt, a_m0_gnt}, 32'h1);
    check("t1_en", a_mem_en, 32'h1);
    check("t1_addr", a_mem_addr, 32'h10);
    check("t1_we", a_mem_we, 32'h0);
    check("t1_busy_T", a_busy, 32'h0);
    @(negedge clk); a_m0_req = 0; #1;
    check("t1_rvalid", {a_m1_rvalid, a_m0_rvalid}, 32'h1);
    check("t1_rdata", a_m0_rdata, 32'hA500_0004);
    check("t1_m1_rdata", a_m1_rdata, 32'h0);
    check("t1_busy_T1", a_busy, 32'h1);
    check("t1_idle_bus", {a_mem_en, a_mem_addr[7:0]}, 32'h0);
    @(negedge clk); #1;
    check("t1_rvalid_end", {a_m1_rvalid, a_m0_rvalid}, 32'h0);
    check("t1_busy_end", a_busy, 32'h0);

    // Saturation: both requesters held high, expect alternation m0,m1,m0,m1
    reset_all();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_m0_req = 1; a_m0_addr = 32'h0; a_m1_req = 1; a_m1_addr = 32'h4; #1;
      check($sformatf("t2_gnt_c%0d", c), {a_m1_gnt, a_m0_gnt}, 32'(t2_gnt[c]));
      check($sformatf("t2_rv_c%0d", c), {a_m1_rvalid, a_m0_rvalid}, 32'(t2_rv[c]));
      check($sformatf("t2_m0d_c%0d", c), a_m0_rdata, t2_rv[c][0] ? 32'hA500_0000 : 32'h0);
      check($sformatf("t2_m1d_c%0d", c), a_m1_rdata, t2_rv[c][1] ? 32'hA500_0001 : 32'h0);
    end
    @(negedge clk); clear_inputs();

    // m1 write with MEM_LAT=3, m0 withdraws during WAIT, then m0 reads it back
    reset_all();
    @(negedge clk);
    b_m1_req = 1; b_m1_we = 1; b_m1_addr = 32'h40; b_m1_wdata = 32'hDEAD_BEEF; #1;
    check("t3_gnt", {b_m1_gnt, b_m0_gnt}, 32'h2);
    check("t3_we", b_mem_we, 32'h1);
    check("t3_addr", b_mem_addr, 32'h40);
    check("t3_wdata", b_mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk); b_m1_req = 0; b_m1_we = 0; b_m0_req = 1; b_m0_addr = 32'h8; #1;
    check("t3_rv_T1", {b_m1_rvalid, b_m0_rvalid}, 32'h0);
    check("t3_m0_held", b_m0_gnt, 32'h0);
    check("t3_busy", b_busy, 32'h1);
    @(negedge clk); b_m0_req = 0; #1;
    check("t3_rv_T2", {b_m1_rvalid, b_m0_rvalid}, 32'h0);
    check("t3_m0_wd", b_m0_gnt, 32'h0);
    @(negedge clk); #1;
    check("t3_rv_T3", {b_m1_rvalid, b_m0_rvalid}, 32'h2);
    check("t3_gnt_T3", {b_m1_gnt, b_m0_gnt}, 32'h0);
    @(negedge clk); #1;
    check("t3_no_gnt", {b_m1_gnt, b_m0_gnt, b_mem_en}, 32'h0);
    check("t3_idle", b_busy, 32'h0);
    @(negedge clk); b_m0_req = 1; b_m0_addr = 32'h40; #1;
    check("t3_rd_gnt", {b_m1_gnt, b_m0_gnt}, 32'h1);
    check("t3_rd_we", b_mem_we, 32'h0);
    @(negedge clk); b_m0_req = 0; #1;
    check("t3_rd_T1", b_m0_rvalid, 32'h0);
    @(negedge clk); #1;
    check("t3_rd_T2", b_m0_rvalid, 32'h0);
    @(negedge clk); #1;
    check("t3_rd_rv", {b_m1_rvalid, b_m0_rvalid}, 32'h1);
    check("t3_rd_data", b_m0_rdata, 32'hDEAD_BEEF);

    // Reset during WAIT of an m0 read; last must return to 1
    reset_all();
    @(negedge clk); a_m0_req = 1; a_m0_addr = 32'h8; #1;
    check("t4_pre_gnt", {a_m1_gnt, a_m0_gnt}, 32'h1);
    @(negedge clk); a_m0_req = 0; #1;
    @(negedge clk); a_m0_req = 1; a_m0_addr = 32'h14; #1;
    check("t4_gnt", {a_m1_gnt, a_m0_gnt}, 32'h1);
    @(negedge clk); a_m1_req = 1; rst_n = 0; #1;
    check("t4_async_ctl", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we, a_busy}, 32'h0);
    check("t4_async_data", a_m0_rdata | a_mem_addr | a_mem_wdata, 32'h0);
    @(negedge clk); #1;
    check("t4_held_ctl", {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_busy}, 32'h0);
    check("t4_held_addr", a_mem_addr, 32'h0);
    @(negedge clk); rst_n = 1; a_m0_req = 0; a_m1_req = 0; #1;
    check("t4_rel_rv0", {a_m1_rvalid, a_m0_rvalid}, 32'h0);
    @(negedge clk); #1;
    check("t4_rel_rv1", {a_m1_rvalid, a_m0_rvalid, a_busy}, 32'h0);
    @(negedge clk); a_m0_req = 1; a_m1_req = 1; a_m0_addr = 32'h0; a_m1_addr = 32'h4; #1;
    check("t4_tie_m0", {a_m1_gnt, a_m0_gnt}, 32'h1);
    @(negedge clk); clear_inputs();

`ifdef MEM_ARB_LOCK_EN
    // m1_lock keeps the bus on m1 for back-to-back transactions
    reset_all();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); a_m1_lock = 1; a_m0_req = 1; a_m1_req = 1; #1;
      check($sformatf("t5_lock_c%0d", c), {a_m1_gnt, a_m0_gnt}, (c % 2 == 0) ? 32'h2 : 32'h0);
    end
    @(negedge clk); a_m1_lock = 0; #1;
    check("t5_unlock", {a_m1_gnt, a_m0_gnt}, 32'h1);
    @(negedge clk); clear_inputs();
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
